// File: rtl/sext_arbiter.sv
// rtl/sext_arbiter.sv - two-requester round-robin sign/zero extender
// Optional per-requester grant counters: define SEXT_ARB_STATS_EN.
module sext_arbiter #(
  parameter int REG_DATA_WIDTH = 16,
  parameter int DATA_2_WIDTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_a,
  input  logic [DATA_2_WIDTH-1:0]   data_a,
  input  logic                      zext_a,
  output logic                      ack_a,
  input  logic                      req_b,
  input  logic [DATA_2_WIDTH-1:0]   data_b,
  input  logic                      zext_b,
  output logic                      ack_b,
  output logic [REG_DATA_WIDTH-1:0] result,
  output logic                      grant_b,
  output logic                      busy
`ifdef SEXT_ARB_STATS_EN
  ,
  output logic [7:0]                cnt_a,
  output logic [7:0]                cnt_b
`endif
);

  localparam int PAD = REG_DATA_WIDTH - DATA_2_WIDTH;

  typedef enum logic [1:0] {IDLE, CAPT, RESP} state_t;

  state_t                    state_q;
  logic [DATA_2_WIDTH-1:0]   field_q;
  logic                      zext_q;
  logic                      grant_b_q;
  logic                      last_b_q;
  logic [REG_DATA_WIDTH-1:0] result_q;
  logic                      ack_a_q;
  logic                      ack_b_q;

  logic                      grant_w;
  logic                      win_b_w;
  logic [REG_DATA_WIDTH-1:0] ext_w;

  // On a tie the requester that was not granted last wins.
  always_comb begin
    grant_w = (state_q == IDLE) && (req_a || req_b);
    win_b_w = (req_a && req_b) ? ~last_b_q : req_b;
  end

  assign ext_w = zext_q ? {{PAD{1'b0}}, field_q}
                        : {{PAD{field_q[DATA_2_WIDTH-1]}}, field_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      field_q   <= '0;
      zext_q    <= 1'b0;
      grant_b_q <= 1'b0;
      last_b_q  <= 1'b1;
      result_q  <= '0;
      ack_a_q   <= 1'b0;
      ack_b_q   <= 1'b0;
    end else begin
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_w) begin
            state_q   <= CAPT;
            grant_b_q <= win_b_w;
            last_b_q  <= win_b_w;
            field_q   <= win_b_w ? data_b : data_a;
            zext_q    <= win_b_w ? zext_b : zext_a;
          end
        end
        CAPT: begin
          result_q <= ext_w;
          state_q  <= RESP;
        end
        RESP: begin
          // Ack registered on the edge leaving RESP: visible two cycles after grant.
          ack_a_q <= ~grant_b_q;
          ack_b_q <= grant_b_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack_a   = ack_a_q;
  assign ack_b   = ack_b_q;
  assign result  = result_q;
  assign grant_b = grant_b_q;
  assign busy    = (state_q != IDLE);

`ifdef SEXT_ARB_STATS_EN
  logic [7:0] cnt_a_q;
  logic [7:0] cnt_b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a_q <= 8'd0;
      cnt_b_q <= 8'd0;
    end else if (grant_w) begin
      if (!win_b_w && cnt_a_q != 8'hFF) cnt_a_q <= cnt_a_q + 8'd1;
      if (win_b_w && cnt_b_q != 8'hFF)  cnt_b_q <= cnt_b_q + 8'd1;
    end
  end

  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_sext_arbiter.sv
// tb/tb_sext_arbiter.sv - directed vector bench for sext_arbiter
module tb_sext_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_a, req_b, zext_a, zext_b;
  logic [3:0]  data_a, data_b;
  logic        ack_a, ack_b, grant_b, busy;
  logic [15:0] result;
`ifdef SEXT_ARB_STATS_EN
  logic [7:0]  cnt_a, cnt_b;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sext_arbiter #(.REG_DATA_WIDTH(16), .DATA_2_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .data_a(data_a), .zext_a(zext_a), .ack_a(ack_a),
    .req_b(req_b), .data_b(data_b), .zext_b(zext_b), .ack_b(ack_b),
    .result(result), .grant_b(grant_b), .busy(busy)
`ifdef SEXT_ARB_STATS_EN
    , .cnt_a(cnt_a), .cnt_b(cnt_b)
`endif
  );

  typedef struct {
    logic        ra, rb;
    logic [3:0]  da, db;
    logic        za, zb;
    logic [15:0] exp_r;
    logic        exp_gb;
  } vec_t;

  vec_t vecs[11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full transaction from an idle arbiter, checking every cycle of it.
  task automatic txn(input vec_t v, input string tag);
    req_a = v.ra; req_b = v.rb;
    data_a = v.da; data_b = v.db;
    zext_a = v.za; zext_b = v.zb;
    step();
    chk({tag, " busy@grant"}, busy, 1);
    chk({tag, " grant_b"}, grant_b, v.exp_gb);
    chk({tag, " ack_a@grant"}, ack_a, 0);
    step();
    chk({tag, " result@capt"}, result, v.exp_r);
    chk({tag, " ack_b@capt"}, ack_b, 0);
    step();
    chk({tag, " ack_a"}, ack_a, !v.exp_gb);
    chk({tag, " ack_b"}, ack_b, v.exp_gb);
    chk({tag, " result"}, result, v.exp_r);
    req_a = 0; req_b = 0;
    step();
    chk({tag, " ack_a off"}, ack_a, 0);
    chk({tag, " ack_b off"}, ack_b, 0);
    chk({tag, " busy off"}, busy, 0);
  endtask

  initial begin
    vecs[0]  = '{1, 1, 4'h7, 4'h8, 0, 0, 16'h0007, 0};
    vecs[1]  = '{1, 1, 4'h7, 4'h8, 0, 0, 16'hFFF8, 1};
    vecs[2]  = '{1, 1, 4'h7, 4'h8, 0, 0, 16'h0007, 0};
    vecs[3]  = '{1, 0, 4'hA, 4'h0, 0, 0, 16'hFFFA, 0};
    vecs[4]  = '{0, 1, 4'h0, 4'hF, 0, 1, 16'h000F, 1};
    vecs[5]  = '{1, 0, 4'h8, 4'h0, 1, 0, 16'h0008, 0};
    vecs[6]  = '{0, 1, 4'hF, 4'h0, 0, 0, 16'h0000, 1};
    vecs[7]  = '{1, 0, 4'hF, 4'h0, 0, 0, 16'hFFFF, 0};
    vecs[8]  = '{1, 1, 4'h1, 4'h7, 0, 1, 16'h0007, 1};
    vecs[9]  = '{0, 1, 4'h1, 4'h8, 0, 1, 16'h0008, 1};
    vecs[10] = '{1, 1, 4'hC, 4'h3, 1, 0, 16'h000C, 0};

    rst_n = 0; req_a = 0; req_b = 0;
    data_a = 0; data_b = 0; zext_a = 0; zext_b = 0;
    step(); step();
    chk("rst result", result, 0);
    chk("rst ack_a", ack_a, 0);
    chk("rst ack_b", ack_b, 0);
    chk("rst busy", busy, 0);
    chk("rst grant_b", grant_b, 0);
    rst_n = 1;
    step();

    for (int i = 0; i < 11; i++) txn(vecs[i], $sformatf("v%0d", i));

    // Field change after the grant edge must not reach result.
    req_a = 1; data_a = 4'h1; zext_a = 0;
    step();
    data_a = 4'hE;
    step(); step();
    chk("latch result", result, 16'h0001);
    chk("latch ack_a", ack_a, 1);
    req_a = 0;
    step();

    // Tie with A last: B wins, A held and granted on the very next IDLE edge.
    req_a = 1; req_b = 1; data_a = 4'h3; zext_a = 1; data_b = 4'hC; zext_b = 0;
    step(); step(); step();
    chk("pend ack_b", ack_b, 1);
    chk("pend result b", result, 16'hFFFC);
    req_b = 0;
    step();
    chk("pend busy", busy, 1);
    chk("pend grant_b", grant_b, 0);
    step(); step();
    chk("pend ack_a", ack_a, 1);
    chk("pend result a", result, 16'h0003);
    req_a = 0;
    step();

    // Reset during CAPT aborts the transaction and re-arms A for ties.
    req_a = 1; req_b = 1; data_a = 4'h5; data_b = 4'h6;
    step();
    chk("abort grant_b", grant_b, 1);
    rst_n = 0;
    #1;
    chk("abort busy", busy, 0);
    chk("abort result", result, 0);
    chk("abort grant_b rst", grant_b, 0);
    req_a = 0; req_b = 0;
    step();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("abort no ack_a %0d", i), ack_a, 0);
      chk($sformatf("abort no ack_b %0d", i), ack_b, 0);
    end
    txn('{1, 1, 4'h7, 4'h8, 0, 0, 16'h0007, 0}, "post-rst tie");

`ifdef SEXT_ARB_STATS_EN
    rst_n = 0;
    step();
    chk("cnt_a rst", cnt_a, 0);
    rst_n = 1;
    step();
    for (int i = 0; i < 3; i++) txn('{1, 0, 4'h1, 4'h0, 1, 0, 16'h0001, 0}, "stat a");
    chk("cnt_a 3", cnt_a, 3);
    chk("cnt_b 0", cnt_b, 0);
    for (int i = 0; i < 300; i++) begin
      req_b = 1; data_b = 4'h2; zext_b = 1;
      step(); step(); step();
      req_b = 0;
      step();
    end
    chk("cnt_b sat", cnt_b, 255);
    chk("cnt_a hold", cnt_a, 3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
